carry_adder: RTL and testbench



---
 rtl/carry_adder.sv | 99 +++++++++
 tb/tb_carry_adder.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/carry_adder.sv
// Registered ripple-carry two's-complement adder with carry-out and signed-overflow flags.
// Latency 1 cycle (2 with CARRY_ADDER_INREG_EN input registers); no backpressure, 1 result/cycle.
module carry_adder #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             c_in,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow,
  output logic             out_valid
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             vld;

`ifdef CARRY_ADDER_INREG_EN
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             ci_q;
  logic             vld_q;

  // Operands are captured only when valid so X on idle inputs never enters the pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      ci_q  <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= in_valid;
      if (in_valid) begin
        a_q  <= x;
        b_q  <= y;
        ci_q <= c_in;
      end
    end
  end

  assign a   = a_q;
  assign b   = b_q;
  assign ci  = ci_q;
  assign vld = vld_q;
`else
  assign a   = x;
  assign b   = y;
  assign ci  = c_in;
  assign vld = in_valid;
`endif

  logic [WIDTH:0]   c_d;
  logic [WIDTH-1:0] sum_d;
  logic             ovf_d;

  always_comb begin
    c_d    = '0;
    sum_d  = '0;
    c_d[0] = ci;
    for (int i = 0; i < WIDTH; i++) begin
      sum_d[i]  = a[i] ^ b[i] ^ c_d[i];
      c_d[i+1]  = (a[i] & b[i]) | (a[i] & c_d[i]) | (b[i] & c_d[i]);
    end
    // Carry into vs. out of the sign bit disagree exactly on signed overflow.
    ovf_d = c_d[WIDTH] ^ c_d[WIDTH-1];
  end

  logic [WIDTH-1:0] sum_q;
  logic             c_out_q;
  logic             ovf_q;
  logic             out_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q       <= '0;
      c_out_q     <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= vld;
      if (vld) begin
        sum_q   <= sum_d;
        c_out_q <= c_d[WIDTH];
        ovf_q   <= ovf_d;
      end
    end
  end

  assign sum       = sum_q;
  assign c_out     = c_out_q;
  assign overflow  = ovf_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_carry_adder.sv
// Self-checking bench for carry_adder: directed table, reset/handshake sequences, exhaustive sweep.
module tb_carry_adder;

`ifdef CARRY_ADDER_INREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk;
  logic       rst_n;
  logic [5:0] x;
  logic [5:0] y;
  logic       c_in;
  logic       in_valid;
  logic [5:0] sum;
  logic       c_out;
  logic       overflow;
  logic       out_valid;

  int n_cmp;
  int n_bad;

  carry_adder #(.WIDTH(6)) dut (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .c_in(c_in), .in_valid(in_valid),
    .sum(sum), .c_out(c_out), .overflow(overflow), .out_valid(out_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic signed [5:0] x;
    logic signed [5:0] y;
    logic              ci;
    logic signed [5:0] s;
    logic              co;
    logic              ov;
  } vec_t;

  vec_t vecs[12];

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got {vld,co,ov,sum}=%b_%b_%b_%b, want %b_%b_%b_%b", name,
               act[8], act[7], act[6], act[5:0], exp[8], exp[7], exp[6], exp[5:0]);
    end
  endtask

  function automatic logic [8:0] model(input int sx, input int sy, input int ci);
    int   t;
    int   u;
    logic [8:0] r;
    t = sx + sy + ci;
    u = (sx & 63) + (sy & 63) + ci;
    r[8]   = 1'b1;
    r[7]   = u[6];
    r[6]   = (t > 31) || (t < -32);
    r[5:0] = t[5:0];
    return r;
  endfunction

  function automatic logic [8:0] outs();
    return {out_valid, c_out, overflow, sum};
  endfunction

  logic [8:0] expq[$];
  logic [8:0] e;
  logic [5:0] last_sum;
  logic       ivp[5];

  initial begin
    n_cmp = 0;
    n_bad = 0;
    vecs[0]  = '{ 6'sd1,   6'sd2,  1'b0,  6'sd3,  1'b0, 1'b0};
    vecs[1]  = '{ 6'sd1,   6'sd2,  1'b1,  6'sd4,  1'b0, 1'b0};
    vecs[2]  = '{ 6'sd31,  6'sd31, 1'b0, -6'sd2,  1'b0, 1'b1};
    vecs[3]  = '{ 6'sd31,  6'sd31, 1'b1, -6'sd1,  1'b0, 1'b1};
    vecs[4]  = '{-6'sd4,  -6'sd5,  1'b0, -6'sd9,  1'b1, 1'b0};
    vecs[5]  = '{-6'sd4,  -6'sd5,  1'b1, -6'sd8,  1'b1, 1'b0};
    vecs[6]  = '{-6'sd32, -6'sd32, 1'b0,  6'sd0,  1'b1, 1'b1};
    vecs[7]  = '{-6'sd32, -6'sd32, 1'b1,  6'sd1,  1'b1, 1'b1};
    vecs[8]  = '{-6'sd32,  6'sd31, 1'b0, -6'sd1,  1'b0, 1'b0};
    vecs[9]  = '{-6'sd8,   6'sd15, 1'b1,  6'sd8,  1'b1, 1'b0};
    vecs[10] = '{ 6'sd0,   6'sd0,  1'b1,  6'sd1,  1'b0, 1'b0};
    vecs[11] = '{ 6'sd0,   6'sd0,  1'b0,  6'sd0,  1'b0, 1'b0};

    rst_n = 1'b0; x = 'x; y = 'x; c_in = 1'bx; in_valid = 1'b0;
    #3;
    check("reset_state", outs(), 9'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("idle_after_reset", outs(), 9'b0);

    // Directed table; operands held for LAT cycles so the output reflects this vector.
    for (int i = 0; i < 12; i++) begin
      x = vecs[i].x; y = vecs[i].y; c_in = vecs[i].ci; in_valid = 1'b1;
      repeat (LAT) step();
      check($sformatf("vec%0d", i), outs(), {1'b1, vecs[i].co, vecs[i].ov, vecs[i].s});
    end

    // Idle with X operands: flags and sum hold, valid drops.
    x = 'x; y = 'x; c_in = 1'bx; in_valid = 1'b0;
    repeat (LAT) step();
    check("idle_hold", outs(), {1'b0, 1'b0, 1'b0, 6'd0});

    // Valid pattern 1,0,1: A=1+2, gap, B=-4+-5.
    ivp = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    last_sum = 6'd0;
    for (int j = 0; j < 5; j++) begin
      in_valid = ivp[j];
      if (j == 0) begin x = 6'd1; y = 6'd2; c_in = 1'b0; end
      else if (j == 2) begin x = 6'b111100; y = 6'b111011; c_in = 1'b0; end
      else begin x = 'x; y = 'x; c_in = 1'bx; end
      step();
      if (j + 1 - LAT >= 0) begin
        if (j + 1 - LAT == 0) last_sum = 6'd3;
        if (j + 1 - LAT == 2) last_sum = 6'b110111;
        check($sformatf("hs_vld%0d", j), {8'd0, out_valid}, {8'd0, ivp[j + 1 - LAT]});
        check($sformatf("hs_sum%0d", j), {3'd0, sum}, {3'd0, last_sum});
      end
    end

    // Mid-stream reset between clock edges discards in-flight work.
    x = 6'd31; y = 6'd31; c_in = 1'b1; in_valid = 1'b1;
    step();
    #2 rst_n = 1'b0;
    #1 check("midreset_immediate", outs(), 9'b0);
    in_valid = 1'b0; x = 'x; y = 'x; c_in = 1'bx;
    @(negedge clk);
    check("midreset_held", outs(), 9'b0);
    rst_n = 1'b1;
    for (int k = 0; k < LAT + 1; k++) begin
      step();
      check($sformatf("midreset_no_vld%0d", k), outs(), 9'b0);
    end

    // Exhaustive back-to-back sweep against the arithmetic model.
    for (int a = -32; a < 32; a++) begin
      for (int b = -32; b < 32; b++) begin
        for (int ci = 0; ci < 2; ci++) begin
          x = a[5:0]; y = b[5:0]; c_in = ci[0]; in_valid = 1'b1;
          expq.push_back(model(a, b, ci));
          step();
          if (expq.size() == LAT) begin
            e = expq.pop_front();
            check($sformatf("sweep x=%0d y=%0d", a, b), outs(), e);
          end
        end
      end
    end
    in_valid = 1'b0; x = 'x; y = 'x; c_in = 1'bx;
    while (expq.size() > 0) begin
      step();
      e = expq.pop_front();
      check("sweep_drain", outs(), e);
    end
    step();
    check("sweep_end_vld", {8'd0, out_valid}, 9'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
